soft_reset_sequencer: RTL and testbench



---
 rtl/soft_reset_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_soft_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soft_reset_sequencer.sv
// -----------------------------------------------------------------------------
// soft_reset_sequencer
//
// Purpose:
//   Drives the active-low reset input of the clock/reset conditioning block.
//   Soft-reset requests from N_REQ sources are merged into one sequence:
//   drain the datapath, hold reset low for HOLD_CYCLES, release, wait
//   SETTLE_CYCLES for the conditioned reset to settle, then pulse done.
//   After a_rst_n the same hold/release/settle runs once, without a done pulse.
//
// Ports:
//   clk            system clock
//   a_rst_n        asynchronous active-low reset
//   req            soft-reset requests, sampled every cycle
//   drain_req      level request asking the datapath to quiesce
//   drain_ack      datapath quiesced (level)
//   rst_ctrl_n     active-low reset to the conditioner
//   busy           a sequence (or the power-on hold) is in progress
//   done           one-cycle pulse at the end of a requested sequence
//   cause          OR of the requests served by the current/last sequence
//   drain_timeout  sticky: the last drain ended by timeout
//   clr_status     clears cause and drain_timeout while idle
// -----------------------------------------------------------------------------
module soft_reset_sequencer #(
  parameter int N_REQ         = 4,
  parameter int HOLD_CYCLES   = 64,
  parameter int SETTLE_CYCLES = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             drain_req,
  input  logic             drain_ack,
  output logic             rst_ctrl_n,
  output logic             busy,
  output logic             done,
  output logic [N_REQ-1:0] cause,
  output logic             drain_timeout,
  input  logic             clr_status
);

  // Counter must span the longest of the three timed intervals.
  localparam int MAX_HS  = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_ALL = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = (DRAIN_TIMEOUT > 0) ? CW'(DRAIN_TIMEOUT - 1) : CNT_ZERO;
  localparam bit            DRAIN_EN    = (DRAIN_TIMEOUT != 0);

  localparam logic [N_REQ-1:0] REQ_ZERO = {N_REQ{1'b0}};

  typedef enum logic [2:0] {
    ST_POR     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_ASSERT  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_SETTLE  = 3'd5
  } state_e;

  // With draining disabled a new sequence goes straight to the reset hold.
  localparam state_e SEQ_ENTRY = DRAIN_EN ? ST_DRAIN : ST_ASSERT;

  state_e            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s, cnt_inc_s;
  logic [N_REQ-1:0]  pend_r, pend_s, pend_merge_s;
  logic [N_REQ-1:0]  cause_r, cause_s;
  logic              dto_r, dto_s;
  logic              done_r, done_s;
  logic              por_seq_r, por_seq_s;
  logic              rst_ctrl_n_r, rst_ctrl_n_s;
  logic              drain_req_r, drain_req_s;
  logic              busy_r, busy_s;

  assign drain_req     = drain_req_r;
  assign rst_ctrl_n    = rst_ctrl_n_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign cause         = cause_r;
  assign drain_timeout = dto_r;

  // Saturating increment of the shared interval counter.
  always_comb begin
    if (cnt_r == CNT_SAT) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Next-state, status and registered-output decode.
  always_comb begin
    state_s      = state_r;
    cause_s      = cause_r;
    pend_s       = pend_r;
    dto_s        = dto_r;
    done_s       = 1'b0;
    por_seq_s    = por_seq_r;
    pend_merge_s = pend_r | req;
    cnt_s        = cnt_inc_s;

    case (state_r)
      // Requests are ignored during the power-on hold.
      ST_POR: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_POR;
        end
      end

      // A clear and a new request in the same cycle: clear, then latch.
      ST_IDLE: begin
        if (clr_status) begin
          cause_s = REQ_ZERO;
          dto_s   = 1'b0;
        end else begin
          cause_s = cause_r;
        end
        if (|req) begin
          cause_s = req;
          state_s = SEQ_ENTRY;
        end else begin
          state_s = ST_IDLE;
        end
      end

      // An ack wins over a timeout landing in the same cycle.
      ST_DRAIN: begin
        cause_s = cause_r | req;
        if (drain_ack) begin
          dto_s   = 1'b0;
          state_s = ST_ASSERT;
        end else if (cnt_r == DRAIN_LAST) begin
          dto_s   = 1'b1;
          state_s = ST_ASSERT;
        end else begin
          state_s = ST_DRAIN;
        end
      end

      ST_ASSERT: begin
        cause_s = cause_r | req;
        if (cnt_r == HOLD_LAST) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_ASSERT;
        end
      end

      // Late requests cannot join a reset already released; queue them.
      ST_RELEASE: begin
        pend_s  = pend_merge_s;
        state_s = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          done_s    = ~por_seq_r;
          por_seq_s = 1'b0;
          pend_s    = REQ_ZERO;
          if (|pend_merge_s) begin
            cause_s = pend_merge_s;
            state_s = SEQ_ENTRY;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          pend_s  = pend_merge_s;
          state_s = ST_SETTLE;
        end
      end

      default: begin
        state_s = ST_POR;
      end
    endcase

    if (state_s != state_r) begin
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_inc_s;
    end

    // Outputs follow the state being entered so they are registered with it.
    rst_ctrl_n_s = ~((state_s == ST_POR) || (state_s == ST_ASSERT));
    drain_req_s  = (state_s == ST_DRAIN);
    busy_s       = (state_s != ST_IDLE);
  end

  // State, counter, status and output registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_r      <= ST_POR;
      cnt_r        <= CNT_ZERO;
      pend_r       <= REQ_ZERO;
      cause_r      <= REQ_ZERO;
      dto_r        <= 1'b0;
      done_r       <= 1'b0;
      por_seq_r    <= 1'b1;
      rst_ctrl_n_r <= 1'b0;
      drain_req_r  <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pend_r       <= pend_s;
      cause_r      <= cause_s;
      dto_r        <= dto_s;
      done_r       <= done_s;
      por_seq_r    <= por_seq_s;
      rst_ctrl_n_r <= rst_ctrl_n_s;
      drain_req_r  <= drain_req_s;
      busy_r       <= busy_s;
    end
  end

endmodule

// File: tb/tb_soft_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_soft_reset_sequencer
//
// Directed bench for soft_reset_sequencer with default parameters
// (N_REQ=4, HOLD=64, SETTLE=32, DRAIN_TIMEOUT=1024). Inputs change and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_soft_reset_sequencer;

  logic       clk;
  logic       a_rst_n;
  logic [3:0] req;
  logic       drain_req;
  logic       drain_ack;
  logic       rst_ctrl_n;
  logic       busy;
  logic       done;
  logic [3:0] cause;
  logic       drain_timeout;
  logic       clr_status;

  int n_assert = 0;
  int n_fail   = 0;
  int falls    = 0;

  soft_reset_sequencer dut (
    .clk          (clk),
    .a_rst_n      (a_rst_n),
    .req          (req),
    .drain_req    (drain_req),
    .drain_ack    (drain_ack),
    .rst_ctrl_n   (rst_ctrl_n),
    .busy         (busy),
    .done         (done),
    .cause        (cause),
    .drain_timeout(drain_timeout),
    .clr_status   (clr_status)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count reset windows (falling edges of rst_ctrl_n).
  always @(negedge rst_ctrl_n) falls <= falls + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of sampled cycles rst_ctrl_n stays low, starting with the current one.
  task automatic measure_low(output int n);
    n = 0;
    while (rst_ctrl_n === 1'b0 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  // Cycles until busy falls, and done pulses seen on the way.
  task automatic wait_idle(output int n, output int dn);
    n  = 0;
    dn = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      n++;
      if (done === 1'b1) dn++;
    end
  endtask

  initial begin
    int n;
    int dn;
    int base;

    a_rst_n    = 1'b1;
    req        = 4'b0000;
    drain_ack  = 1'b1;
    clr_status = 1'b0;
    #3;
    a_rst_n = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_rst_ctrl_n", rst_ctrl_n, 1'b0);
    check("rst_drain_req", drain_req, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_cause", cause, 4'b0000);
    check("rst_drain_timeout", drain_timeout, 1'b0);

    // Power-on hold: 64 low cycles, busy 33 cycles more, no done
    a_rst_n = 1'b1;
    measure_low(n);
    check("por_low_cycles", n, 64);
    wait_idle(n, dn);
    check("por_busy_tail", n, 33);
    check("por_no_done", dn, 0);

    // Single request, drain_ack already high
    base = falls;
    req  = 4'b0010;
    tick();
    check("s2_drain_req", drain_req, 1'b1);
    check("s2_still_high", rst_ctrl_n, 1'b1);
    check("s2_cause_latched", cause, 4'b0010);
    req = 4'b0000;
    tick();
    // Low in the third cycle counting the request cycle.
    check("s2_latency_low", rst_ctrl_n, 1'b0);
    check("s2_drain_dropped", drain_req, 1'b0);
    measure_low(n);
    check("s2_low_cycles", n, 64);
    wait_idle(n, dn);
    check("s2_busy_tail", n, 33);
    check("s2_done_once", dn, 1);
    tick();
    check("s2_done_one_cycle", done, 1'b0);
    check("s2_cause", cause, 4'b0010);
    check("s2_drain_timeout", drain_timeout, 1'b0);
    check("s2_windows", falls - base, 1);

    // Drain timeout
    drain_ack = 1'b0;
    req       = 4'b0001;
    tick();
    req = 4'b0000;
    n   = 0;
    while (drain_req === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    check("s3_drain_cycles", n, 1024);
    check("s3_low_after_drain", rst_ctrl_n, 1'b0);
    check("s3_timeout_set", drain_timeout, 1'b1);
    measure_low(n);
    check("s3_low_cycles", n, 64);
    wait_idle(n, dn);
    check("s3_done_once", dn, 1);
    check("s3_timeout_sticky", drain_timeout, 1'b1);
    check("s3_cause", cause, 4'b0001);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("s3_clr_timeout", drain_timeout, 1'b0);
    check("s3_clr_cause", cause, 4'b0000);

    // Second request during ASSERT is absorbed; clr_status ignored when busy
    drain_ack = 1'b1;
    base      = falls;
    req       = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    repeat (8) tick();
    req        = 4'b1000;
    clr_status = 1'b1;
    tick();
    req        = 4'b0000;
    clr_status = 1'b0;
    check("s4_cause_merged", cause, 4'b1010);
    measure_low(n);
    check("s4_low_remaining", n, 55);
    wait_idle(n, dn);
    check("s4_done_once", dn, 1);
    check("s4_cause", cause, 4'b1010);
    repeat (5) tick();
    check("s4_no_retrigger", busy, 1'b0);
    check("s4_windows", falls - base, 1);

    // Request during SETTLE chains a second sequence
    base = falls;
    req  = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    measure_low(n);
    check("s5_first_low", n, 64);
    tick();
    repeat (4) tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("s5_cause_unchanged", cause, 4'b0001);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("s5_done_time", n, 27);
    check("s5_busy_chained", busy, 1'b1);
    check("s5_drain_chained", drain_req, 1'b1);
    check("s5_cause_pending", cause, 4'b0100);
    tick();
    check("s5_done_one_cycle", done, 1'b0);
    check("s5_second_low", rst_ctrl_n, 1'b0);
    measure_low(n);
    check("s5_second_low_cycles", n, 64);
    wait_idle(n, dn);
    check("s5_second_done", dn, 1);
    check("s5_cause_final", cause, 4'b0100);
    repeat (5) tick();
    check("s5_idle", busy, 1'b0);
    check("s5_windows", falls - base, 2);

    // Asynchronous reset mid-ASSERT
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    repeat (5) tick();
    check("s6_pre_cause", cause, 4'b0001);
    #1;
    a_rst_n = 1'b0;
    #1;
    check("s6_async_rst_ctrl_n", rst_ctrl_n, 1'b0);
    check("s6_async_busy", busy, 1'b1);
    check("s6_async_cause", cause, 4'b0000);
    check("s6_async_drain_req", drain_req, 1'b0);
    check("s6_async_done", done, 1'b0);
    check("s6_async_timeout", drain_timeout, 1'b0);
    #1;
    a_rst_n = 1'b1;
    measure_low(n);
    check("s6_por_low", n, 64);
    wait_idle(n, dn);
    check("s6_busy_tail", n, 33);
    check("s6_no_done", dn, 0);
    check("s6_cause", cause, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
